imem_loader: RTL

Writer-side counterpart of the instruction fetch path. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into instruction memory starting at the text-segment base. Loading stops after the all-zero terminator word is written, which is the word the fetch side treats as end-of-program. Sits between a host/byte source and the instruction memory write port, ahead of the PC/fetch logic.

---
 rtl/imem_loader.sv | 99 +++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction loader: assembles big-endian 32-bit words and writes them
// sequentially from BASE_ADDR until an all-zero terminator word or capacity is reached.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int unsigned MAX_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, DONE, ERROR} state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t     state;
  logic [1:0] idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= ASSEMBLE;
            idx        <= 2'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 16'd0;
            mem_addr   <= BASE_ADDR;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
          end
        end
        ASSEMBLE: begin
          if (in_valid && in_ready) begin
            // first byte of the stream lands in the most-significant lane
            case (idx)
              2'd0:    mem_wdata[31:24] <= in_byte;
              2'd1:    mem_wdata[23:16] <= in_byte;
              2'd2:    mem_wdata[15:8]  <= in_byte;
              default: mem_wdata[7:0]   <= in_byte;
            endcase
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              mem_we   <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_we     <= 1'b0;
            word_count <= word_count + 16'd1;
            idx        <= 2'd0;
            // terminator wins over capacity so a zero word in the last slot ends cleanly
            if (mem_wdata == 32'd0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (word_count + 16'd1 == MAX_CNT) begin
              state <= ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= ASSEMBLE;
              mem_addr <= mem_addr + 32'd4;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
